dmem_unit: RTL and testbench

- Blocking data-memory interface for one core: services the memory-stage request bundle from the core datapath.
- Converts each request into a single word-aligned bus transaction with byte strobes.
- Returns sign/zero-extended load data and drives the cache-miss stall (cmiss_stall) back to control while a transaction is outstanding.
- Sits directly downstream of the datapath's memory stage, between the core and the shared memory bus.

---
 rtl/dmem_unit_pkg.sv | 68 ++++++
 rtl/dmem_unit_if.sv | 21 ++
 rtl/dmem_unit_load_align.sv | 23 ++
 rtl/dmem_unit.sv | 139 +++++++++++++
 tb/tb_dmem_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_unit_pkg.sv
// Shared types for the data-memory unit: core request encodings, FSM states,
// bus request bundle, and the alignment / strobe / lane-replication helpers.
package Bundle;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemoryWriteSignal;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd5,
    MT_HU = 3'd6
  } MemoryMaskType;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_REQ,
    DM_WAIT,
    DM_DONE
  } DmemState;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } BusReq;

  function automatic logic is_aligned(input logic [1:0] lane, input MemoryMaskType typ);
    case (typ)
      MT_B, MT_BU: return 1'b1;
      MT_H, MT_HU: return ~lane[0];
      default:     return (lane == 2'b00);
    endcase
  endfunction

  // Word-aligned bus beat; reads carry no strobes and no write data.
  function automatic BusReq build_bus_req(input logic [31:0] addr, input MemoryWriteSignal fcn,
                                          input MemoryMaskType typ, input logic [31:0] data);
    BusReq r;
    r.addr  = {addr[31:2], 2'b00};
    r.we    = (fcn == M_XWR);
    r.wstrb = '0;
    r.wdata = '0;
    if (r.we) begin
      case (typ)
        MT_B, MT_BU: begin
          r.wstrb = 4'b0001 << addr[1:0];
          r.wdata = {4{data[7:0]}};
        end
        MT_H, MT_HU: begin
          r.wstrb = 4'b0011 << addr[1:0];
          r.wdata = {2{data[15:0]}};
        end
        default: begin
          r.wstrb = 4'b1111;
          r.wdata = data;
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// Shared memory-bus port: request handshake, write fields and read/ack return.
interface dmem_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/dmem_unit_load_align.sv
// Load lane extraction: shifts the addressed byte/half down and sign- or
// zero-extends it according to the access type.
module dmem_load_align
  import Bundle::*;
(
  input  logic [31:0]   rdata,
  input  logic [1:0]    addr,
  input  MemoryMaskType typ,
  output logic [31:0]   data
);
  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (typ)
      MT_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      MT_BU:   data = {24'h0, shifted[7:0]};
      MT_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      MT_HU:   data = {16'h0, shifted[15:0]};
      default: data = shifted;
    endcase
  end
endmodule

// File: rtl/dmem_unit.sv
// Blocking data-memory unit: one bus transaction per memory-stage request,
// stalling the core until the load data or store ack returns (or times out).
module dmem_unit
  import Bundle::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  input  MemoryWriteSignal req_fcn,
  input  MemoryMaskType    req_typ,
  input  logic [31:0]      req_data,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic             stall,
  output logic             misaligned,
  output logic             bus_err,
  dmem_unit_if.master      bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  DmemState      state_q, state_d;
  BusReq         breq_q, cur_req, out_req;
  logic [1:0]    lane_q;
  MemoryMaskType typ_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   resp_q, ext_data;
  logic          err_q;
  logic          accept, load_resp, timeout, out_valid, timed_out;

  dmem_load_align u_align (
    .rdata (bus.bus_rdata),
    .addr  (lane_q),
    .typ   (typ_q),
    .data  (ext_data)
  );

  assign cur_req   = build_bus_req(req_addr, req_fcn, req_typ, req_data);
  assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_resp  = 1'b0;
    timeout    = 1'b0;
    out_valid  = 1'b0;
    out_req    = '0;
    stall      = 1'b0;
    misaligned = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      DM_IDLE: begin
        // The IDLE accept path is combinational from the inputs, so reset must gate it.
        if (req_valid && !rst) begin
          if (is_aligned(req_addr[1:0], req_typ)) begin
            accept    = 1'b1;
            out_valid = 1'b1;
            out_req   = cur_req;
            stall     = 1'b1;
            state_d   = bus.bus_req_ready ? DM_WAIT : DM_REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      DM_REQ: begin
        out_valid = 1'b1;
        out_req   = breq_q;
        stall     = 1'b1;
        if (bus.bus_req_ready) begin
          state_d = DM_WAIT;
        end else if (timed_out) begin
          timeout = 1'b1;
          state_d = DM_DONE;
        end
      end
      DM_WAIT: begin
        stall = 1'b1;
        if (bus.bus_resp_valid) begin
          load_resp = 1'b1;
          state_d   = DM_DONE;
        end else if (timed_out) begin
          timeout = 1'b1;
          state_d = DM_DONE;
        end
      end
      DM_DONE: begin
        resp_valid = 1'b1;
        state_d    = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breq_q <= '0;
      lane_q <= '0;
      typ_q  <= MT_X;
      cnt_q  <= '0;
      resp_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        breq_q <= cur_req;
        lane_q <= req_addr[1:0];
        typ_q  <= req_typ;
        cnt_q  <= '0;
      end else if ((state_q == DM_REQ || state_q == DM_WAIT) && !timed_out) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (load_resp) begin
        resp_q <= breq_q.we ? '0 : ext_data;
      end else if (timeout) begin
        resp_q <= '0;
        err_q  <= 1'b1;
      end else if (state_q == DM_DONE) begin
        resp_q <= '0;
        err_q  <= 1'b0;
      end
    end
  end

  assign resp_data         = resp_q;
  assign bus_err           = (state_q == DM_DONE) && err_q;
  assign bus.bus_req_valid = out_valid;
  assign bus.bus_addr      = out_req.addr;
  assign bus.bus_we        = out_req.we;
  assign bus.bus_wstrb     = out_req.wstrb;
  assign bus.bus_wdata     = out_req.wdata;
endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: table-driven transactions, a response
// scoreboard, and hand-written timeout / reset sequences.
module tb_dmem_unit;
  import Bundle::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [31:0]      req_addr;
  MemoryWriteSignal req_fcn;
  MemoryMaskType    req_typ;
  logic [31:0]      req_data;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             stall;
  logic             misaligned;
  logic             bus_err;

  dmem_unit_if bus();

  dmem_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_fcn    (req_fcn),
    .req_typ    (req_typ),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0]      addr;
    MemoryWriteSignal fcn;
    MemoryMaskType    typ;
    logic [31:0]      din;
    logic [31:0]      rdata;
    int unsigned      rdly;
    logic             mis;
    logic [3:0]       strb;
    logic [31:0]      wdata;
    logic [31:0]      resp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every resp_valid must match the oldest expected response.
  always @(negedge clk) begin
    #2;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_data %h with no response outstanding", resp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_bus_err", {31'h0, bus_err}, {31'h0, e.err});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_fcn   = v.fcn;
    req_typ   = v.typ;
    req_data  = v.din;
    bus.bus_req_ready  = (v.rdly == 0);
    bus.bus_resp_valid = 1'b0;
    bus.bus_rdata      = '0;
    #1;
    if (v.mis) begin
      check("mis_flag", {31'h0, misaligned}, 32'h1);
      check("mis_stall", {31'h0, stall}, 32'h0);
      check("mis_bus_valid", {31'h0, bus.bus_req_valid}, 32'h0);
      check("mis_wstrb", {28'h0, bus.bus_wstrb}, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("mis_no_resp", {31'h0, resp_valid}, 32'h0);
      check("mis_clear", {31'h0, misaligned}, 32'h0);
      return;
    end
    check("acc_stall", {31'h0, stall}, 32'h1);
    check("acc_misaligned", {31'h0, misaligned}, 32'h0);
    check("acc_bus_valid", {31'h0, bus.bus_req_valid}, 32'h1);
    check("acc_bus_addr", bus.bus_addr, {v.addr[31:2], 2'b00});
    check("acc_bus_we", {31'h0, bus.bus_we}, {31'h0, v.fcn == M_XWR});
    check("acc_wstrb", {28'h0, bus.bus_wstrb}, {28'h0, v.strb});
    check("acc_wdata", bus.bus_wdata, v.wdata);
    exp_q.push_back('{v.resp, 1'b0});
    for (int k = 1; k <= int'(v.rdly); k++) begin
      @(negedge clk);
      bus.bus_req_ready = (k == int'(v.rdly));
      #1;
      check("req_stall", {31'h0, stall}, 32'h1);
      check("req_bus_valid", {31'h0, bus.bus_req_valid}, 32'h1);
      check("req_bus_addr", bus.bus_addr, {v.addr[31:2], 2'b00});
      check("req_wstrb", {28'h0, bus.bus_wstrb}, {28'h0, v.strb});
      check("req_wdata", bus.bus_wdata, v.wdata);
    end
    @(negedge clk);
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = v.rdata;
    #1;
    check("wait_stall", {31'h0, stall}, 32'h1);
    check("wait_bus_valid", {31'h0, bus.bus_req_valid}, 32'h0);
    check("wait_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    bus.bus_resp_valid = 1'b0;
    #1;
    check("done_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("done_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("idle_stall", {31'h0, stall}, 32'h0);
    check("idle_bus_addr", bus.bus_addr, 32'h0);
    check("idle_wstrb", {28'h0, bus.bus_wstrb}, 32'h0);
    check("sb_drained", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h100, M_XRD, MT_W,  32'hFFFFFFFF, 32'hDEADBEEF, 0, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{32'h103, M_XRD, MT_B,  32'hFFFFFFFF, 32'h80FF0000, 0, 1'b0, 4'h0, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{32'h103, M_XRD, MT_BU, 32'hFFFFFFFF, 32'h80FF0000, 0, 1'b0, 4'h0, 32'h0,        32'h00000080};
    vecs[3]  = '{32'h102, M_XRD, MT_H,  32'hFFFFFFFF, 32'h80FF0000, 0, 1'b0, 4'h0, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{32'h102, M_XRD, MT_HU, 32'hFFFFFFFF, 32'h80FF0000, 1, 1'b0, 4'h0, 32'h0,        32'h000080FF};
    vecs[5]  = '{32'h100, M_XRD, MT_B,  32'hFFFFFFFF, 32'h1234567F, 0, 1'b0, 4'h0, 32'h0,        32'h0000007F};
    vecs[6]  = '{32'h204, M_XWR, MT_W,  32'h11223344, 32'hFFFFFFFF, 1, 1'b0, 4'hF, 32'h11223344, 32'h0};
    vecs[7]  = '{32'h206, M_XWR, MT_H,  32'h0000BEEF, 32'hFFFFFFFF, 0, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0};
    vecs[8]  = '{32'h201, M_XWR, MT_B,  32'h000000AB, 32'hFFFFFFFF, 3, 1'b0, 4'h2, 32'hABABABAB, 32'h0};
    vecs[9]  = '{32'h203, M_XWR, MT_B,  32'h12345655, 32'hFFFFFFFF, 2, 1'b0, 4'h8, 32'h55555555, 32'h0};
    vecs[10] = '{32'h102, M_XRD, MT_W,  32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{32'h101, M_XWR, MT_H,  32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[12] = '{32'h103, M_XRD, MT_HU, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[13] = '{32'h101, M_XRD, MT_BU, 32'hFFFFFFFF, 32'h0000A500, 1, 1'b0, 4'h0, 32'h0,        32'h000000A5};

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_fcn   = M_XRD;
    req_typ   = MT_W;
    req_data  = '0;
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b0;
    bus.bus_rdata      = '0;
    #1;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check("rst_bus_valid", {31'h0, bus.bus_req_valid}, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Timeout: accepted read never answered, then a late response arrives.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300; req_fcn = M_XRD; req_typ = MT_W;
    bus.bus_req_ready = 1'b1;
    #1;
    check("to_accept_stall", {31'h0, stall}, 32'h1);
    exp_q.push_back('{32'h0, 1'b1});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.bus_req_ready = 1'b0;
      #1;
      check("to_wait_stall", {31'h0, stall}, 32'h1);
      check("to_wait_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    @(negedge clk);
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = 32'h12345678;
    #1;
    check("to_done_valid", {31'h0, resp_valid}, 32'h1);
    check("to_done_err", {31'h0, bus_err}, 32'h1);
    check("to_done_stall", {31'h0, stall}, 32'h0);
    check("to_done_bus_valid", {31'h0, bus.bus_req_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("to_late_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("to_late_err", {31'h0, bus_err}, 32'h0);
    check("to_late_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    bus.bus_resp_valid = 1'b0;
    #1;
    check("to_late_ignored", {31'h0, resp_valid}, 32'h0);

    // Asynchronous reset while waiting for the bus, with a stale response afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h400; req_fcn = M_XRD; req_typ = MT_W;
    bus.bus_req_ready = 1'b1;
    @(negedge clk);
    bus.bus_req_ready = 1'b0;
    #1;
    check("rw_wait_stall", {31'h0, stall}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("rw_async_stall", {31'h0, stall}, 32'h0);
    check("rw_async_bus_valid", {31'h0, bus.bus_req_valid}, 32'h0);
    check("rw_async_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = 32'hCAFEF00D;
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rw_stale_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rw_stale_stall", {31'h0, stall}, 32'h0);
    bus.bus_resp_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rw_stale_still_idle", {31'h0, resp_valid}, 32'h0);
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    check("sb_final_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
